envelope_follower: RTL
======================

Name: envelope_follower

Overview:
- Inverse of the envelope generator: takes an audio sample stream and recovers an amplitude envelope plus a derived gate.
- Used for sidechain, auto-gate and envelope-to-modulation routing.
- Output gate, state and envelope have the same widths and encodings as the envelope generator's Gate, ADSRstate and Envelope. They can feed any envelope consumer directly.

Parameters:
- WAVE_MAX, 24'hFFFFFF, full-scale unsigned sample/envelope value
- WAVE_MID, 24'h800000, zero level of offset-binary input samples

Ports:
- Clock  in  1  system clock, all state on posedge
- Reset  in  1  asynchronous, active-low reset
- SampleValid  in  1  one-cycle strobe, Sample is valid
- Sample  in  24  offset-binary audio sample
- Linear  in  1  1 = linear step mode, 0 = exponential (shift) mode
- AttackStep, ReleaseStep  in  24 each  linear-mode step per sample
- AttackShift, ReleaseShift  in  5 each  exponential-mode divisor exponent
- ThresholdOn, ThresholdOff  in  24 each  gate hysteresis levels
- HoldSamples  in  16  samples the gate stays open after falling below ThresholdOff
- Envelope  out  24  tracked envelope
- EnvelopeValid  out  1  one-cycle strobe, Envelope/Gate updated
- Gate  out  1  derived gate
- FollowState  out  2  00 CLOSED, 01 OPEN, 10 HOLD

Behaviour:
- Reset (async, Reset==0): Envelope=0, EnvelopeValid=0, Gate=0, FollowState=00, hold counter=0, pipeline valid=0, magnitude reg=0.
- Stage 1 (registered on SampleValid): Mag = 2*|Sample-WAVE_MID|, saturated to WAVE_MAX.
  - Sample=0 -> FFFFFF (sat); Sample=FFFFFF -> FFFFFE; Sample=800000 -> 0.
- Stage 2 (cycle after stage 1 valid): envelope update, then gate FSM on the NEW envelope. Both are registered in the same cycle.
- Latency: SampleValid at cycle t -> EnvelopeValid high at t+2 for exactly one cycle.
- Fully pipelined: SampleValid on every cycle gives EnvelopeValid on every cycle.
- Attack (Mag > Envelope): diff = Mag-Envelope; step = Linear ? AttackStep : (diff>>AttackShift)+1; Envelope += min(step, diff). Never overshoots Mag.
- Release (Mag < Envelope): diff = Envelope-Mag; step = Linear ? ReleaseStep : (diff>>ReleaseShift)+1; Envelope -= min(step, diff). Never undershoots Mag.
- Mag == Envelope: no change. A step of 0 in linear mode freezes Envelope.
- Internal arithmetic is 25 bits wide; no wrap-around is possible.
- Gate FSM (evaluated only on stage-2 valid cycles; otherwise holds):
  - CLOSED: Env >= ThresholdOn -> OPEN, Gate=1.
  - OPEN: Env < ThresholdOff -> if HoldSamples==0 go CLOSED (Gate=0), else go HOLD and load counter=HoldSamples.
  - HOLD: Env >= ThresholdOn -> OPEN (counter discarded). Else decrement the counter; when it reaches 0 -> CLOSED, Gate=0. Gate stays 1 throughout HOLD.
  - Gate == (FollowState != CLOSED) at all times.
- Config inputs are sampled at the cycle they are used. Mid-stream changes take effect on the next sample with no glitch.
- Reset asserted mid-operation clears immediately (asynchronously). The first valid output after release requires a fresh SampleValid.

Optional Feature:
- Macro ENVELOPE_FOLLOWER_PEAK_EN.
- Defined: adds output PeakLevel[23:0].
  - Reset to 0.
  - Loaded with Envelope on each CLOSED->OPEN transition.
  - Updated to max(PeakLevel, Envelope) on every valid update while the gate is open.
  - Frozen while CLOSED.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package (synth_pkg): WAVE_MAX, WAVE_MID, and FollowState encodings FOLLOW_CLOSED/OPEN/HOLD.
  - Same 2-bit width as the ADSRstate encodings.
- One natural sub-module: envelope_step. Combinational step/clamp for one direction, instantiated twice (attack, release).

Test Plan:
- Reset: drive Reset=0 mid-stream with Envelope=0x400000 -> all outputs 0 at once; FollowState=00.
- Rectify/latency: Sample=0x000000 at t -> Mag=FFFFFF; linear AttackStep=0x100000 -> Envelope=0x100000 with EnvelopeValid at t+2. Back-to-back samples give 0x200000, 0x300000 on consecutive cycles.
- Clamp: Envelope=0x7FFF00, Mag=0x800000, AttackStep=0x1000 -> Envelope=0x800000 exactly. Next samples hold 0x800000.
- Exponential: Linear=0, Envelope=0, Mag=0x800000, AttackShift=1 -> 0x400001, then 0x600001.
- Gate hysteresis/hold:
  - Setup: ThresholdOn=0x300000, ThresholdOff=0x100000, HoldSamples=3.
  - Envelope rises past 0x300000 -> OPEN, Gate=1.
  - Envelope falls below 0x100000 -> HOLD; Gate drops on the 3rd subsequent sample.
  - Repeat with a re-rise during HOLD -> returns to OPEN, Gate never drops.
- HoldSamples=0: falling below ThresholdOff -> CLOSED on that same update.
  - With ENVELOPE_FOLLOWER_PEAK_EN defined: PeakLevel equals the maximum envelope reached during the open period.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synth constants, follower state encodings and rectifier.
// Used by envelope_follower and its step sub-module.
package synth_pkg;

  localparam logic [23:0] WAVE_MAX = 24'hFFFFFF;
  localparam logic [23:0] WAVE_MID = 24'h800000;

  typedef enum logic [1:0] {
    FOLLOW_CLOSED = 2'b00,
    FOLLOW_OPEN   = 2'b01,
    FOLLOW_HOLD   = 2'b10
  } follow_state_e;

  // 2*|s-mid|; only s==0 exceeds full scale
  function automatic logic [23:0] rectify(
    input logic [23:0] s
  );
    logic [24:0] d;
    if (s >= WAVE_MID)
      d = {1'b0, s - WAVE_MID} << 1;
    else
      d = {1'b0, WAVE_MID - s} << 1;
    return d[24] ? WAVE_MAX : d[23:0];
  endfunction

endpackage

// File: rtl/envelope_step.sv
// One-direction envelope step: distance hi-lo, linear or shift step,
// clamped to the distance. Ports: hi, lo, linear, step_lin, shift -> delta.
module envelope_step (
  input  logic [23:0] hi,
  input  logic [23:0] lo,
  input  logic        linear,
  input  logic [23:0] step_lin,
  input  logic [4:0]  shift,
  output logic [23:0] delta
);

  logic [24:0] diff;
  logic [24:0] step;

  // result only meaningful when hi > lo
  always_comb begin
    diff  = {1'b0, hi} - {1'b0, lo};
    step  = linear ? {1'b0, step_lin}
                   : (diff >> shift) + 25'd1;
    delta = (step < diff) ? step[23:0]
                          : diff[23:0];
  end

endmodule

// File: rtl/envelope_follower.sv
// Envelope follower: rectify -> attack/release track -> gate FSM.
// In: Clock, Reset(n), SampleValid, Sample, Linear, Attack/Release
// Step/Shift, ThresholdOn/Off, HoldSamples. Out: Envelope,
// EnvelopeValid, Gate, FollowState (+PeakLevel if
// ENVELOPE_FOLLOWER_PEAK_EN is defined).
module envelope_follower
  import synth_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SampleValid,
  input  logic [23:0] Sample,
  input  logic        Linear,
  input  logic [23:0] AttackStep,
  input  logic [23:0] ReleaseStep,
  input  logic [4:0]  AttackShift,
  input  logic [4:0]  ReleaseShift,
  input  logic [23:0] ThresholdOn,
  input  logic [23:0] ThresholdOff,
  input  logic [15:0] HoldSamples,
  output logic [23:0] Envelope,
  output logic        EnvelopeValid,
  output logic        Gate,
  output logic [1:0]  FollowState
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
  ,
  output logic [23:0] PeakLevel
`endif
);

  logic [23:0]   mag;
  logic          mag_valid;
  logic [23:0]   atk_delta;
  logic [23:0]   rel_delta;
  logic [23:0]   env_next;
  logic [15:0]   hold_cnt;
  follow_state_e state;

  envelope_step u_attack (
    .hi       (mag),
    .lo       (Envelope),
    .linear   (Linear),
    .step_lin (AttackStep),
    .shift    (AttackShift),
    .delta    (atk_delta)
  );

  envelope_step u_release (
    .hi       (Envelope),
    .lo       (mag),
    .linear   (Linear),
    .step_lin (ReleaseStep),
    .shift    (ReleaseShift),
    .delta    (rel_delta)
  );

  always_comb begin
    env_next = Envelope;
    if (mag > Envelope)
      env_next = Envelope + atk_delta;
    else if (mag < Envelope)
      env_next = Envelope - rel_delta;
  end

  assign FollowState = state;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mag           <= '0;
      mag_valid     <= 1'b0;
      Envelope      <= '0;
      EnvelopeValid <= 1'b0;
      Gate          <= 1'b0;
      hold_cnt      <= '0;
      state         <= FOLLOW_CLOSED;
    end else begin
      mag_valid     <= SampleValid;
      EnvelopeValid <= mag_valid;
      if (SampleValid)
        mag <= rectify(Sample);
      if (mag_valid) begin
        Envelope <= env_next;
        // gate decisions look at the envelope being written now
        unique case (state)
          FOLLOW_CLOSED: begin
            if (env_next >= ThresholdOn) begin
              state <= FOLLOW_OPEN;
              Gate  <= 1'b1;
            end
          end
          FOLLOW_OPEN: begin
            if (env_next < ThresholdOff) begin
              if (HoldSamples == '0) begin
                state <= FOLLOW_CLOSED;
                Gate  <= 1'b0;
              end else begin
                state    <= FOLLOW_HOLD;
                hold_cnt <= HoldSamples;
              end
            end
          end
          FOLLOW_HOLD: begin
            if (env_next >= ThresholdOn) begin
              state    <= FOLLOW_OPEN;
              hold_cnt <= '0;
            end else if (hold_cnt <= 16'd1) begin
              state    <= FOLLOW_CLOSED;
              Gate     <= 1'b0;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt - 16'd1;
            end
          end
          default: begin
            state <= FOLLOW_CLOSED;
            Gate  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ENVELOPE_FOLLOWER_PEAK_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      PeakLevel <= '0;
    end else if (mag_valid) begin
      if (state == FOLLOW_CLOSED) begin
        if (env_next >= ThresholdOn)
          PeakLevel <= env_next;
      end else if (env_next > PeakLevel) begin
        PeakLevel <= env_next;
      end
    end
  end
`endif

endmodule
